mem_writeback_stage: RTL and testbench
======================================

# mem_writeback_stage

Consumer end of the EX->MEM pipeline interface in the myMIPS 5-stage core. Takes the registered ALU result, destination register and load flag from the execution stage, performs loads against a handshaked data memory (multi-cycle, with timeout), and presents a registered write-back port to the register file. Upstream is stalled while a load is outstanding.

## Interface
- DATA_W, 32, datapath and memory word width
- REG_W, 5, register index width
- TIMEOUT, 16, max WAIT cycles before a load is aborted (>=2)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ALUout  in  DATA_W  EX result; byte address when XM_lwFlag=1
- XM_RD  in  REG_W  destination register from EX
- XM_lwFlag  in  1  current EX->MEM entry is a load
- stall  out  1  combinational; upstream holds XM_* while high
- mem_req  out  1  registered load request
- mem_addr  out  DATA_W  registered load address (ALUout, low 2 bits zero)
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge; sampled only in WAIT
- MW_we  out  1  register-file write enable, one-cycle pulse
- MW_RD  out  REG_W  write-back register index
- MW_data  out  DATA_W  write-back data
- load_err  out  1  one-cycle pulse: misaligned or timed-out load

## Operation
- States: IDLE, WAIT. Reset: IDLE; mem_req=0, mem_addr=0, MW_we=0, MW_RD=0, MW_data=0, load_err=0, timeout counter=0.
- IDLE, XM_lwFlag=0: MW_RD<=XM_RD, MW_data<=ALUout, MW_we<=(XM_RD!=0). Stay IDLE.
- IDLE, XM_lwFlag=1, ALUout[1:0]!=0: no request; MW_we<=0, load_err<=1. Stay IDLE.
- IDLE, XM_lwFlag=1, aligned: mem_req<=1, mem_addr<=ALUout, latch XM_RD internally, MW_we<=0, counter<=0, go WAIT.
- WAIT, mem_ack=1: MW_data<=mem_rdata, MW_RD<=latched RD, MW_we<=(latched RD!=0), mem_req<=0, go IDLE.
- WAIT, no ack, counter==TIMEOUT-1: mem_req<=0, MW_we<=0, load_err<=1, go IDLE. Otherwise counter++.
- Ack and timeout in the same cycle: ack wins, no error.
- mem_ack outside WAIT: ignored.
- stall = (IDLE & XM_lwFlag & aligned) | (WAIT & ~mem_ack & ~(counter==TIMEOUT-1)).
- Register 0 never written: MW_we=0 whenever destination is 0.
- rst mid-WAIT: immediate return to IDLE with reset values; pending ack dropped.

## Timing
- ALU pass-through: XM_* in cycle N -> MW_* valid cycle N+1, latency 1.
- Load: accepted cycle N (stall=1), mem_req high from N+1, ack in cycle N+k (k>=1) -> MW_we pulse N+k+1; stall low in ack cycle so upstream advances at the same edge.
- Minimum load latency 2 cycles; maximum TIMEOUT+1 before load_err.
- MW_we and load_err high exactly one cycle per event.

## Configuration
- MW_PERF_EN defined: adds outputs perf_loads (32b, completed loads) and perf_stalls (32b, cycles with stall=1), reset 0, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package mips_pkg: DATA_W, REG_W defaults, mw_state_t enum (IDLE, WAIT), ZERO_REG constant.
- One sub-module: mem_load_ctrl (FSM, timeout counter, mem_req/mem_addr, stall); top instantiates it and holds the MW_* write-back registers.

## Test plan
- Reset: assert rst mid-run -> all outputs 0, state IDLE, stall=0.
- ALU op: ALUout=32'h0000_0010, XM_RD=5'd3, lw=0 -> next cycle MW_we=1, MW_RD=3, MW_data=32'h10; XM_RD=0 -> MW_we=0.
- Load, ack after 3 cycles: ALUout=32'h100, XM_RD=5'd8 -> mem_req from N+1, mem_addr=32'h100, stall=1 until ack cycle, MW_data=mem_rdata=32'hCAFE_F00D, MW_RD=8, MW_we pulse at ack+1.
- Misaligned: ALUout=32'h102, lw=1 -> no mem_req, load_err pulse, MW_we=0, stall=0.
- Timeout: load, never ack -> mem_req drops after TIMEOUT=16 WAIT cycles, load_err pulse, MW_we=0; ack in final cycle -> normal completion, no error.
- Back-to-back: load then ALU op held by upstream -> ALU result written cycle after load write-back; with MW_PERF_EN, perf_loads=1 and perf_stalls equals stalled cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the myMIPS memory/write-back slice.
//   MIPS_DATA_W : default datapath and memory word width
//   MIPS_REG_W  : default register index width
//   ZERO_REG    : architectural zero register index (never written)
//   mw_state_t  : load controller states (IDLE, WAIT)
package mips_pkg;

    localparam int unsigned MIPS_DATA_W = 32;
    localparam int unsigned MIPS_REG_W  = 5;
    localparam int unsigned ZERO_REG    = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mw_state_t;

endpackage

// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: load sequencer between the EX->MEM latch and data memory.
// Issues a registered, handshaked load request, waits for the acknowledge
// with a timeout, and stalls upstream while a load is outstanding.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   alu_out           EX result / load byte address
//   xm_rd, xm_lw      destination register and load flag from EX
//   mem_ack           one-cycle acknowledge, only honoured in WAIT
//   stall             combinational upstream hold
//   mem_req, mem_addr registered load request and word address
//   pass_en           IDLE, non-load: write back the ALU result this cycle
//   ld_done, ld_rd    load acknowledged this cycle, and its destination
//   err_evt           misaligned or timed-out load this cycle
module mem_load_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = MIPS_DATA_W,
    parameter int unsigned REG_W   = MIPS_REG_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [REG_W-1:0]  xm_rd,
    input  logic              xm_lw,
    input  logic              mem_ack,
    output logic              stall,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic              pass_en,
    output logic              ld_done,
    output logic [REG_W-1:0]  ld_rd,
    output logic              err_evt
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mw_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              aligned;
    logic              cnt_last;

    assign aligned  = (alu_out[1:0] == 2'b00);
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        stall   = 1'b0;
        pass_en = 1'b0;
        ld_done = 1'b0;
        err_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!xm_lw) begin
                    pass_en = 1'b1;
                end else if (!aligned) begin
                    err_evt = 1'b1;
                end else begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    addr_d  = {alu_out[DATA_W-1:2], 2'b00};
                    rd_d    = xm_rd;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    ld_done = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (cnt_last) begin
                    err_evt = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign ld_rd    = rd_q;

endmodule

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: MEM/WB stage of the myMIPS core. Passes ALU results
// straight to the register-file write port, performs loads through
// mem_load_ctrl, and reports misaligned/timed-out loads on load_err.
// Optional build macro MW_PERF_EN adds perf_loads / perf_stalls counters.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ALUout, XM_RD, XM_lwFlag  EX->MEM entry
//   stall                     combinational upstream hold
//   mem_req, mem_addr         registered load request / word address
//   mem_rdata, mem_ack        load data and one-cycle acknowledge
//   MW_we, MW_RD, MW_data     registered register-file write port
//   load_err                  one-cycle error pulse
//   perf_loads, perf_stalls   (MW_PERF_EN only) completed loads, stalled cycles
module mem_writeback_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = MIPS_DATA_W,
    parameter int unsigned REG_W   = MIPS_REG_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ALUout,
    input  logic [REG_W-1:0]  XM_RD,
    input  logic              XM_lwFlag,
    output logic              stall,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              MW_we,
    output logic [REG_W-1:0]  MW_RD,
    output logic [DATA_W-1:0] MW_data,
    output logic              load_err
`ifdef MW_PERF_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stalls
`endif
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    logic              pass_en;
    logic              ld_done;
    logic [REG_W-1:0]  ld_rd;
    logic              err_evt;

    logic              we_q, we_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    mem_load_ctrl #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .alu_out  (ALUout),
        .xm_rd    (XM_RD),
        .xm_lw    (XM_lwFlag),
        .mem_ack  (mem_ack),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .pass_en  (pass_en),
        .ld_done  (ld_done),
        .ld_rd    (ld_rd),
        .err_evt  (err_evt)
    );

    // Write-back register holds its index/data between writes; only the
    // enable and error are pulses.
    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        err_d  = err_evt;
        if (pass_en) begin
            rd_d   = XM_RD;
            data_d = ALUout;
            we_d   = (XM_RD != ZERO_IDX);
        end else if (ld_done) begin
            rd_d   = ld_rd;
            data_d = mem_rdata;
            we_d   = (ld_rd != ZERO_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign MW_we    = we_q;
    assign MW_RD    = rd_q;
    assign MW_data  = data_q;
    assign load_err = err_q;

`ifdef MW_PERF_EN
    logic [31:0] loads_q, stalls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loads_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (ld_done) loads_q <= loads_q + 32'd1;
            if (stall)   stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_loads  = loads_q;
    assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_mem_writeback_stage.sv
// tb_mem_writeback_stage: directed and randomized checks of
// mem_writeback_stage against a transaction-level reference model.
module tb_mem_writeback_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUout;
    logic [4:0]  XM_RD;
    logic        XM_lwFlag;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        MW_we;
    logic [4:0]  MW_RD;
    logic [31:0] MW_data;
    logic        load_err;
`ifdef MW_PERF_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stalls;
`endif

    mem_writeback_stage #(
        .DATA_W  (32),
        .REG_W   (5),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ALUout    (ALUout),
        .XM_RD     (XM_RD),
        .XM_lwFlag (XM_lwFlag),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .MW_we     (MW_we),
        .MW_RD     (MW_RD),
        .MW_data   (MW_data),
        .load_err  (load_err)
`ifdef MW_PERF_EN
        ,
        .perf_loads  (perf_loads),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: one outstanding load with its elapsed wait count.
    bit          m_busy;
    int          m_waited;
    logic [4:0]  m_pend_rd;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_err;
    int          m_loads;
    int          m_stalls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_pend_rd = '0;
        m_req = 0; m_addr = '0; m_we = 0; m_rd = '0; m_data = '0; m_err = 0;
        m_loads = 0; m_stalls = 0;
    endtask

    function automatic logic model_stall();
        if (!m_busy) return XM_lwFlag && (ALUout % 4 == 0);
        return !mem_ack && (m_waited + 1 < TO);
    endfunction

    task automatic model_step();
        m_we  = 0;
        m_err = 0;
        if (!m_busy) begin
            if (!XM_lwFlag) begin
                m_rd = XM_RD; m_data = ALUout; m_we = (XM_RD != 0);
            end else if (ALUout % 4 != 0) begin
                m_err = 1;
            end else begin
                m_busy = 1; m_waited = 0; m_pend_rd = XM_RD;
                m_req = 1; m_addr = ALUout;
            end
        end else if (mem_ack) begin
            m_rd = m_pend_rd; m_data = mem_rdata; m_we = (m_pend_rd != 0);
            m_busy = 0; m_req = 0; m_loads++;
        end else if (m_waited + 1 == TO) begin
            m_err = 1; m_busy = 0; m_req = 0;
        end else begin
            m_waited++;
        end
    endtask

    task automatic chk_outputs();
        chk("mem_req", mem_req, m_req);
        chk("mem_addr", mem_addr, m_addr);
        chk("MW_we", MW_we, m_we);
        chk("MW_RD", MW_RD, m_rd);
        chk("MW_data", MW_data, m_data);
        chk("load_err", load_err, m_err);
    endtask

    // Entered and left at posedge+1: drive, check stall, clock, check registers.
    task automatic cycle(input logic lw, input logic [31:0] a, input logic [4:0] rd,
                         input logic ack, input logic [31:0] rdat, output logic st);
        XM_lwFlag = lw; ALUout = a; XM_RD = rd; mem_ack = ack; mem_rdata = rdat;
        #1;
        st = model_stall();
        chk("stall", stall, st);
        if (st) m_stalls++;
        model_step();
        @(posedge clk); #1;
        chk_outputs();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        st;
        logic        c_lw;
        logic [31:0] c_a;
        logic [4:0]  c_rd;

        rst = 1; XM_lwFlag = 0; ALUout = '0; XM_RD = '0; mem_ack = 0; mem_rdata = '0;
        model_reset();
        @(posedge clk); #1;
        chk_outputs();
        chk("stall_rst", stall, 1'b0);
        rst = 0;

        // ALU pass-through, then a write to register 0.
        cycle(0, 32'h0000_0010, 5'd3, 0, '0, st);
        cycle(0, 32'h0000_0020, 5'd0, 0, '0, st);

        // Load acknowledged on the third wait cycle, followed by an ALU op.
        cycle(1, 32'h0000_0100, 5'd8, 0, '0, st);
        cycle(1, 32'h0000_0100, 5'd8, 0, '0, st);
        cycle(1, 32'h0000_0100, 5'd8, 0, '0, st);
        cycle(1, 32'h0000_0100, 5'd8, 1, 32'hCAFE_F00D, st);
        chk("ack_no_stall", st, 1'b0);
        cycle(0, 32'h0000_0055, 5'd9, 0, '0, st);

        // Misaligned load; ack outside WAIT is ignored.
        cycle(1, 32'h0000_0102, 5'd4, 1, 32'h1111_1111, st);
        cycle(0, 32'h0000_0001, 5'd0, 0, '0, st);

        // Timeout: never acknowledged.
        cycle(1, 32'h0000_0200, 5'd5, 0, '0, st);
        for (int i = 0; i < TO; i++) cycle(1, 32'h0000_0200, 5'd5, 0, '0, st);
        chk("timeout_err", load_err, 1'b1);
        cycle(0, 32'h0000_0000, 5'd0, 0, '0, st);

        // Ack in the final wait cycle completes normally.
        cycle(1, 32'h0000_0300, 5'd6, 0, '0, st);
        for (int i = 0; i < TO - 1; i++) cycle(1, 32'h0000_0300, 5'd6, 0, '0, st);
        cycle(1, 32'h0000_0300, 5'd6, 1, 32'h1234_5678, st);
        chk("late_ack_we", MW_we, 1'b1);
        cycle(0, 32'h0000_0000, 5'd0, 0, '0, st);

`ifdef MW_PERF_EN
        chk("perf_loads", perf_loads, 32'(m_loads));
        chk("perf_stalls", perf_stalls, 32'(m_stalls));
`endif

        // Reset in the middle of a wait drops the pending ack.
        cycle(1, 32'h0000_0400, 5'd7, 0, '0, st);
        cycle(1, 32'h0000_0400, 5'd7, 0, '0, st);
        XM_lwFlag = 0; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        rst = 1;
        #1;
        model_reset();
        chk_outputs();
        chk("stall_rst_mid", stall, 1'b0);
        @(posedge clk); #1;
        rst = 0;
        cycle(0, 32'h0000_0077, 5'd2, 1, '0, st);

        // Randomized traffic; upstream holds XM_* while stalled.
        st = 0; c_lw = 0; c_a = '0; c_rd = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!st) begin
                c_lw = ($urandom_range(0, 9) < 4);
                c_a  = $urandom;
                if ($urandom_range(0, 9) < 7) c_a[1:0] = 2'b00;
                c_rd = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 7) == 0) c_rd = '0;
            end
            cycle(c_lw, c_a, c_rd, ($urandom_range(0, 3) == 0), $urandom, st);
        end

`ifdef MW_PERF_EN
        chk("perf_loads_rnd", perf_loads, 32'(m_loads));
        chk("perf_stalls_rnd", perf_stalls, 32'(m_stalls));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
